// File: rtl/pipe_adder.sv
// -----------------------------------------------------------------------------
// pipe_adder
//   Pipelined add/subtract unit with carry, overflow and zero flags.
//   A WIDTH-bit operation is split into STAGES slices of SLICE = WIDTH/STAGES
//   bits. Stage k adds slice k and hands its carry to stage k+1 through a
//   register, so one slice is resolved per clock. The last stage also forms
//   the flags and registers them together with the sum.
//
//   Optional feature macro: ADDER_SAT_EN
//     defined   -> extra input `sat`, captured with the operands; when sat=1
//                  and the result overflows, the sum clamps to the most
//                  positive / most negative value (sign taken from a).
//     undefined -> no `sat` port, the result always wraps.
//
// Parameters
//   WIDTH   operand/result width (WIDTH % STAGES must be 0)
//   STAGES  pipeline depth / number of slices
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   in_valid      operand set presented
//   in_ready      unit accepts operands this cycle
//   a, b          operands
//   cy_in         carry-in (add) / borrow-in (sub)
//   sub           0 = add, 1 = subtract
//   sat           (ADDER_SAT_EN only) clamp on signed overflow
//   out_valid     result available
//   out_ready     consumer takes result this cycle
//   sum           result
//   carryflag     carry out of the MSB (subtract: 1 = no borrow)
//   overflowflag  signed two's complement overflow (raw, before clamping)
//   zeroflag      final sum == 0
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. The whole pipe moves as one (adv = !out_valid | out_ready); bubbles
// move with it and are never squeezed out. While out_valid & !out_ready the
// pipe freezes and in_ready is low, so a source must hold its operands until
// it sees in_ready. Latency is STAGES cycles, throughput one op per cycle.
// -----------------------------------------------------------------------------
module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cy_in,
  input  logic             sub,
`ifdef ADDER_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryflag,
  output logic             overflowflag,
  output logic             zeroflag
);

  localparam int SLICE = WIDTH / STAGES;
  localparam int MSB   = WIDTH - 1;
  localparam int LAST  = STAGES - 1;
  // Intermediate register banks sit between stages; with STAGES=1 there are
  // none, but the arrays keep a minimum size of one so they stay legal.
  localparam int NREG  = (STAGES > 1) ? STAGES - 1 : 1;

  // ---------------------------------------------------------------------------
  // Global advance
  // ---------------------------------------------------------------------------
  logic w_adv;
  logic r_out_v;

  assign w_adv    = !r_out_v || out_ready;
  assign in_ready = w_adv;

  // ---------------------------------------------------------------------------
  // Per-stage inputs (w_*[k] is what stage k works on this cycle)
  // ---------------------------------------------------------------------------
  logic             w_v     [STAGES];
  logic [WIDTH-1:0] w_a     [STAGES];
  logic [WIDTH-1:0] w_b     [STAGES];  // b already inverted for subtract
  logic [WIDTH-1:0] w_s     [STAGES];  // result slices resolved so far
  logic             w_c     [STAGES];  // carry into this stage's slice
  logic [SLICE:0]   w_sl    [STAGES];  // slice sum including carry out
  logic [WIDTH-1:0] w_snext [STAGES];  // w_s with this stage's slice filled in
`ifdef ADDER_SAT_EN
  logic             w_sat   [STAGES];
`endif

  // Inter-stage registers. Operands are carried at full width for
  // simplicity; slices already consumed are simply never read again and
  // drop out during synthesis.
  logic             r_v     [NREG];
  logic [WIDTH-1:0] r_a     [NREG];
  logic [WIDTH-1:0] r_b     [NREG];
  logic [WIDTH-1:0] r_s     [NREG];
  logic             r_c     [NREG];
`ifdef ADDER_SAT_EN
  logic             r_sat   [NREG];
`endif

  // Stage 0 is fed straight from the ports. Subtraction is a + ~b + ~cy_in,
  // so a borrow-in of 1 becomes a carry-in of 0 and vice versa.
  assign w_v[0] = in_valid;
  assign w_a[0] = a;
  assign w_b[0] = sub ? ~b : b;
  assign w_c[0] = sub ? ~cy_in : cy_in;
  assign w_s[0] = '0;
`ifdef ADDER_SAT_EN
  assign w_sat[0] = sat;
`endif

  // ---------------------------------------------------------------------------
  // Slice adders and inter-stage registers
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    assign w_sl[k] = {1'b0, w_a[k][k*SLICE +: SLICE]}
                   + {1'b0, w_b[k][k*SLICE +: SLICE]}
                   + {{SLICE{1'b0}}, w_c[k]};

    // Slices above k are still zero in w_s, so OR-ing the new slice in is
    // enough to place it.
    assign w_snext[k] = w_s[k] | (WIDTH'(w_sl[k][SLICE-1:0]) << (k*SLICE));

    if (k < LAST) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          r_v[k] <= 1'b0;
          r_a[k] <= '0;
          r_b[k] <= '0;
          r_s[k] <= '0;
          r_c[k] <= 1'b0;
`ifdef ADDER_SAT_EN
          r_sat[k] <= 1'b0;
`endif
        end else if (w_adv) begin
          r_v[k] <= w_v[k];
          // Payload only moves with a real op; a bubble leaves it untouched.
          if (w_v[k]) begin
            r_a[k] <= w_a[k];
            r_b[k] <= w_b[k];
            r_s[k] <= w_snext[k];
            r_c[k] <= w_sl[k][SLICE];
`ifdef ADDER_SAT_EN
            r_sat[k] <= w_sat[k];
`endif
          end
        end
      end

      assign w_v[k+1] = r_v[k];
      assign w_a[k+1] = r_a[k];
      assign w_b[k+1] = r_b[k];
      assign w_s[k+1] = r_s[k];
      assign w_c[k+1] = r_c[k];
`ifdef ADDER_SAT_EN
      assign w_sat[k+1] = r_sat[k];
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Final stage: flags, optional clamp, output registers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_fin;
  logic             w_cy;
  logic             w_ov;

  assign w_raw = w_snext[LAST];
  assign w_cy  = w_sl[LAST][SLICE];
  // Signed overflow: both effective operands share a sign and the raw
  // result has the other sign.
  assign w_ov  = (w_a[LAST][MSB] == w_b[LAST][MSB]) && (w_raw[MSB] != w_a[LAST][MSB]);

`ifdef ADDER_SAT_EN
  // On overflow the true result lies beyond the range on the side of a's
  // sign: positive a clamps to 0x7F..F, negative a to 0x80..0.
  always_comb begin
    w_fin = w_raw;
    if (w_sat[LAST] && w_ov) begin
      w_fin = w_a[LAST][MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
    end
  end
`else
  assign w_fin = w_raw;
`endif

  logic [WIDTH-1:0] r_sum;
  logic             r_cy;
  logic             r_ov;
  logic             r_z;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_v <= 1'b0;
      r_sum   <= '0;
      r_cy    <= 1'b0;
      r_ov    <= 1'b0;
      r_z     <= 1'b0;
    end else if (w_adv) begin
      r_out_v <= w_v[LAST];
      if (w_v[LAST]) begin
        r_sum <= w_fin;
        r_cy  <= w_cy;
        r_ov  <= w_ov;
        r_z   <= (w_fin == '0);
      end
    end
  end

  assign out_valid    = r_out_v;
  assign sum          = r_sum;
  assign carryflag    = r_cy;
  assign overflowflag = r_ov;
  assign zeroflag     = r_z;

endmodule

// File: tb/tb_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_pipe_adder
//   Scoreboard bench for pipe_adder. The driver pushes the expected
//   {zero, overflow, carry, sum} for every accepted op into exp_q; a separate
//   monitor pops and compares whenever the DUT hands out a result. A second
//   instance (WIDTH=8, STAGES=1) covers the degenerate single-stage build.
// -----------------------------------------------------------------------------
module tb_pipe_adder;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // DUT 32-bit / 4 stages
  // ---------------------------------------------------------------------------
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cy_in = 1'b0;
  logic        sub = 1'b0;
`ifdef ADDER_SAT_EN
  logic        sat_i = 1'b0;
`endif
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
  logic        carryflag, overflowflag, zeroflag;

  pipe_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .cy_in        (cy_in),
    .sub          (sub),
`ifdef ADDER_SAT_EN
    .sat          (sat_i),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .sum          (sum),
    .carryflag    (carryflag),
    .overflowflag (overflowflag),
    .zeroflag     (zeroflag)
  );

  // ---------------------------------------------------------------------------
  // DUT 8-bit / 1 stage
  // ---------------------------------------------------------------------------
  logic       in_valid8 = 1'b0;
  logic       in_ready8;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
`ifdef ADDER_SAT_EN
  logic       sat8 = 1'b0;
`endif
  logic       out_valid8;
  logic [7:0] sum8;
  logic       cy8, ov8, z8;

  pipe_adder #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid8),
    .in_ready     (in_ready8),
    .a            (a8),
    .b            (b8),
    .cy_in        (1'b0),
    .sub          (1'b0),
`ifdef ADDER_SAT_EN
    .sat          (sat8),
`endif
    .out_valid    (out_valid8),
    .out_ready    (1'b1),
    .sum          (sum8),
    .carryflag    (cy8),
    .overflowflag (ov8),
    .zeroflag     (z8)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [34:0] exp_q[$];   // {z, ov, cy, sum}
  int          lat_q[$];   // accept cycle, or -1 when latency is not checked
  int          n_cmp = 0;
  int          n_err = 0;
  bit          rdy_mode = 1'b0;  // 0: out_ready held high, 1: random

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [34:0] pk(input logic [31:0] s, input logic cy, input logic ov, input logic z);
    return {z, ov, cy, s};
  endfunction

  // Reference for the random phase: one full-width addition.
  function automatic logic [34:0] model(input logic [31:0] av, input logic [31:0] bv,
                                        input logic ci, input logic sb, input logic st);
    logic [31:0] be;
    logic [32:0] full;
    logic [31:0] s;
    logic        ov;
    be   = sb ? ~bv : bv;
    full = {1'b0, av} + {1'b0, be} + {32'd0, (sb ? ~ci : ci)};
    s    = full[31:0];
    ov   = (av[31] == be[31]) && (s[31] != av[31]);
`ifdef ADDER_SAT_EN
    if (st && ov) s = av[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return pk(s, full[32], ov, (s == 32'd0));
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive_cycle(input logic v, input logic [31:0] av, input logic [31:0] bv,
                             input logic ci, input logic sb, input logic st, output logic acc);
    @(negedge clk);
    in_valid = v;
    a        = av;
    b        = bv;
    cy_in    = ci;
    sub      = sb;
`ifdef ADDER_SAT_EN
    sat_i    = st;
`endif
    out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    check("in_ready", in_ready, !(out_valid && !out_ready));
    acc = v && in_ready;
  endtask

  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic ci,
                      input logic sb, input logic st, input logic [34:0] exp);
    logic acc;
    for (int t = 0; t < 64; t++) begin
      drive_cycle(1'b1, av, bv, ci, sb, st, acc);
      if (acc) begin
        exp_q.push_back(exp);
        lat_q.push_back(rdy_mode ? -1 : cyc);
        return;
      end
    end
    n_err++;
    $display("FAIL send_timeout: op a=%0h b=%0h never accepted", av, bv);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      idle(1);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d results still outstanding", exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
    idle(2);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    logic [34:0] e;
    int          acc_cyc;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got sum %0h with no op outstanding", sum);
        end else begin
          e       = exp_q.pop_front();
          acc_cyc = lat_q.pop_front();
          check("sum",      sum,          e[31:0]);
          check("carry",    carryflag,    e[32]);
          check("overflow", overflowflag, e[33]);
          check("zero",     zeroflag,     e[34]);
          if (acc_cyc >= 0) check("latency", cyc - acc_cyc, 4);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] ra, rb;
    logic        rc, rs, rt;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum",       sum,       0);
    check("rst_flags",     {carryflag, overflowflag, zeroflag}, 0);
    check("rst_in_ready",  in_ready,  1);
    check("rst8_out_valid", out_valid8, 0);

    // Single-stage 8-bit build: 0x80 + 0x80 one clock later
    @(negedge clk);
    in_valid8 = 1'b1;
    a8 = 8'h80;
    b8 = 8'h80;
    #1;
    check("s1_in_ready", in_ready8, 1);
    @(negedge clk);
    in_valid8 = 1'b0;
    #2;
    check("s1_out_valid", out_valid8, 1);
    check("s1_sum",       sum8,       8'h00);
    check("s1_cy_ov_z",   {cy8, ov8, z8}, 3'b111);
    @(negedge clk);
    #2;
    check("s1_bubble", out_valid8, 0);

    // Directed vectors, out_ready held high (latency checked)
    rdy_mode = 1'b0;
    send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, pk(32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0));
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, pk(32'h0000_0000, 1'b1, 1'b0, 1'b1));
    send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b0, pk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
    send(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 1'b0, pk(32'h0000_0002, 1'b1, 1'b0, 1'b0));
    // borrow-in: 10 - 3 - 1
    send(32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 1'b0, pk(32'h0000_0006, 1'b1, 1'b0, 1'b0));
    // carry ripples across every slice boundary
    send(32'h00FF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0, pk(32'h0100_0000, 1'b0, 1'b0, 1'b0));
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0, pk(32'h0000_0000, 1'b1, 1'b0, 1'b1));
    // most negative minus one: signed overflow on subtract
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0, pk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
    // equal operands subtract to zero without borrow
    send(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 1'b0, pk(32'h0000_0000, 1'b1, 1'b0, 1'b1));
`ifdef ADDER_SAT_EN
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, pk(32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0));
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, pk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
    send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, pk(32'h8000_0000, 1'b1, 1'b1, 1'b0));
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, pk(32'h8000_0000, 1'b1, 1'b1, 1'b0));
`endif
    drain();

    // Back-to-back random ops under random backpressure
    rdy_mode = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ra = $urandom();
      rb = $urandom();
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      rt = 1'($urandom_range(0, 1));
      if (i == 0) begin
        ra = 32'h7FFF_FFF0;
        rb = 32'h0000_0100;
        rs = 1'b0;
      end
      send(ra, rb, rc, rs, rt, model(ra, rb, rc, rs, rt));
    end
    drain();
    rdy_mode = 1'b0;

    // Reset with three ops in flight: nothing may come out afterwards
    send(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0, pk(32'h2, 1'b0, 1'b0, 1'b0));
    send(32'h0000_0002, 32'h0000_0002, 1'b0, 1'b0, 1'b0, pk(32'h4, 1'b0, 1'b0, 1'b0));
    send(32'h0000_0003, 32'h0000_0003, 1'b0, 1'b0, 1'b0, pk(32'h6, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;  // accept must lose to reset
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_sum",       sum,       0);
    check("post_rst_flags",     {carryflag, overflowflag, zeroflag}, 0);
    check("post_rst_in_ready",  in_ready,  1);
    idle(10);

    // Pipe still works after reset
    send(32'h0000_0100, 32'h0000_0001, 1'b0, 1'b1, 1'b0, pk(32'h0000_00FF, 1'b1, 1'b0, 1'b0));
    drain();

    check("leftover", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
